alu_arbiter: RTL and testbench

- Shares the single 8-bit ALU between two requesters (e.g. execute stage and address/compare unit).
- Round-robin arbitration, valid/ready request and response handshakes, one operation in flight.
- Drives the external ALU's operand/control inputs and registers its result.
- Computes the zero flag locally from the registered result; the ALU's own zero output is not used.

---
 rtl/alu_arbiter.sv | 145 ++++++++++++++
 tb/tb_alu_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external 8-bit ALU between two requesters.
// Round-robin grant, valid/ready request and response handshakes, and a
// single operation in flight (IDLE -> EXEC -> RESP -> IDLE).
// The zero flag is derived locally from the captured result.
// Optional feature macro: ALU_ARB_STATS_EN adds saturating 16-bit per-requester
// grant counters (grantCount0, grantCount1).
module alu_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       reqValid,
  output logic [1:0]       reqReady,
  input  logic [WIDTH-1:0] reqA0,
  input  logic [WIDTH-1:0] reqB0,
  input  logic [WIDTH-1:0] reqA1,
  input  logic [WIDTH-1:0] reqB1,
  input  logic [1:0]       reqOp0,
  input  logic [1:0]       reqOp1,
  output logic [1:0]       rspValid,
  input  logic [1:0]       rspReady,
  output logic [WIDTH-1:0] rspResult,
  output logic             rspZero,
  output logic [WIDTH-1:0] aluA,
  output logic [WIDTH-1:0] aluB,
  output logic [1:0]       aluControl,
  input  logic [WIDTH-1:0] aluResult,
  output logic             busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]      grantCount0,
  output logic [15:0]      grantCount1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_r;
  logic   ptr_r;        // requester favoured when both are valid
  logic   id_r;         // owner of the operation in flight
  logic   grant_s;
  logic   any_valid_s;
  logic   accept_s;
  logic   rsp_done_s;

  // Select the candidate requester: a lone requester wins, otherwise the pointer decides.
  always_comb begin
    any_valid_s = |reqValid;
    case (reqValid)
      2'b01:   grant_s = 1'b0;
      2'b10:   grant_s = 1'b1;
      default: grant_s = ptr_r;
    endcase
  end

  // Offer ready to the granted requester only while idle and not being reset.
  always_comb begin
    if ((state_r == IDLE) && !reset && any_valid_s) begin
      reqReady = grant_s ? 2'b10 : 2'b01;
    end else begin
      reqReady = 2'b00;
    end
  end

  // Handshake qualifiers for the request and response sides.
  always_comb begin
    accept_s   = |(reqValid & reqReady);
    rsp_done_s = (state_r == RESP) && (|(rspValid & rspReady));
  end

  // Main control FSM; all ALU-facing and response outputs are registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      ptr_r      <= 1'b0;
      id_r       <= 1'b0;
      aluA       <= {WIDTH{1'b0}};
      aluB       <= {WIDTH{1'b0}};
      aluControl <= 2'b00;
      rspValid   <= 2'b00;
      rspResult  <= {WIDTH{1'b0}};
      rspZero    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            aluA       <= grant_s ? reqA1  : reqA0;
            aluB       <= grant_s ? reqB1  : reqB0;
            aluControl <= grant_s ? reqOp1 : reqOp0;
            id_r       <= grant_s;
            ptr_r      <= ~grant_s;
            busy       <= 1'b1;
            state_r    <= EXEC;
          end else begin
            state_r    <= IDLE;
          end
        end
        EXEC: begin
          // ALU is combinational: its result is valid by the end of this cycle.
          rspResult <= aluResult;
          rspZero   <= (aluResult == {WIDTH{1'b0}});
          rspValid  <= id_r ? 2'b10 : 2'b01;
          state_r   <= RESP;
        end
        RESP: begin
          if (rsp_done_s) begin
            rspValid <= 2'b00;
            busy     <= 1'b0;
            state_r  <= IDLE;
          end else begin
            state_r  <= RESP;
          end
        end
        default: begin
          rspValid <= 2'b00;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Per-requester saturating grant counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      grantCount0 <= 16'h0000;
      grantCount1 <= 16'h0000;
    end else begin
      if (accept_s && !grant_s && (grantCount0 != 16'hFFFF)) begin
        grantCount0 <= grantCount0 + 16'h0001;
      end
      if (accept_s && grant_s && (grantCount1 != 16'hFFFF)) begin
        grantCount1 <= grantCount1 + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with an expected-response
// scoreboard; the external ALU is modelled here as combinational logic.
module tb_alu_arbiter;

  logic       clock;
  logic       reset;
  logic [1:0] reqValid;
  logic [1:0] reqReady;
  logic [7:0] reqA0, reqB0, reqA1, reqB1;
  logic [1:0] reqOp0, reqOp1;
  logic [1:0] rspValid;
  logic [1:0] rspReady;
  logic [7:0] rspResult;
  logic       rspZero;
  logic [7:0] aluA, aluB;
  logic [1:0] aluControl;
  logic [7:0] aluResult;
  logic       busy;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] grantCount0, grantCount1;
`endif

  typedef struct packed {
    logic [1:0] valid_bits;
    logic [7:0] result;
    logic       zero;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_arbiter #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqA0(reqA0), .reqB0(reqB0), .reqA1(reqA1), .reqB1(reqB1),
    .reqOp0(reqOp0), .reqOp1(reqOp1),
    .rspValid(rspValid), .rspReady(rspReady),
    .rspResult(rspResult), .rspZero(rspZero),
    .aluA(aluA), .aluB(aluB), .aluControl(aluControl),
    .aluResult(aluResult), .busy(busy)
`ifdef ALU_ARB_STATS_EN
    , .grantCount0(grantCount0), .grantCount1(grantCount1)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  // External ALU stand-in.
  always_comb aluResult = alu_model(aluA, aluB, aluControl);

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int n, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] op);
    exp_t e;
    e.valid_bits = (n == 1) ? 2'b10 : 2'b01;
    e.result     = alu_model(a, b, op);
    e.zero       = (e.result == 8'h00);
    exp_q.push_back(e);
  endtask

  // Wait (bounded) at negedges for any reqReady bit, then compare it.
  task automatic wait_grant(input string tag, input logic [1:0] exp_ready);
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (reqReady != 2'b00) break;
    end
    chk(tag, {14'd0, reqReady}, {14'd0, exp_ready});
  endtask

  // Wait (bounded) for a response and compare it against the scoreboard head.
  task automatic wait_rsp(input string tag);
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (rspValid != 2'b00) break;
    end
    chk({tag, "_qsize"}, 16'(exp_q.size() != 0), 16'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_valid"},  {14'd0, rspValid}, {14'd0, e.valid_bits});
      chk({tag, "_result"}, {8'd0, rspResult}, {8'd0, e.result});
      chk({tag, "_zero"},   {15'd0, rspZero},  {15'd0, e.zero});
    end
  endtask

  task automatic run_single(input string tag, input int n, input logic [7:0] a,
                            input logic [7:0] b, input logic [1:0] op);
    @(posedge clock); #1;
    if (n == 0) begin reqA0 = a; reqB0 = b; reqOp0 = op; reqValid = 2'b01; end
    else        begin reqA1 = a; reqB1 = b; reqOp1 = op; reqValid = 2'b10; end
    push_exp(n, a, b, op);
    wait_grant({tag, "_grant"}, (n == 1) ? 2'b10 : 2'b01);
    @(posedge clock); #1;
    reqValid = 2'b00;
    wait_rsp(tag);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_reqReady"}, {14'd0, reqReady}, 16'd0);
    chk({tag, "_rspValid"}, {14'd0, rspValid}, 16'd0);
    chk({tag, "_rspResult"}, {8'd0, rspResult}, 16'd0);
    chk({tag, "_rspZero"}, {15'd0, rspZero}, 16'd0);
    chk({tag, "_aluA"}, {8'd0, aluA}, 16'd0);
    chk({tag, "_aluB"}, {8'd0, aluB}, 16'd0);
    chk({tag, "_aluCtl"}, {14'd0, aluControl}, 16'd0);
    chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
  endtask

  initial begin
    reset = 1'b1; reqValid = 2'b00; rspReady = 2'b11;
    reqA0 = 8'h00; reqB0 = 8'h00; reqA1 = 8'h00; reqB1 = 8'h00;
    reqOp0 = 2'b00; reqOp1 = 2'b00;

    // Reset values
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_reset_outputs("rst");
    @(posedge clock); #1;
    reset = 1'b0;

    // Single request: 0x05 + 0x03
    reqA0 = 8'h05; reqB0 = 8'h03; reqOp0 = 2'b00; reqValid = 2'b01;
    push_exp(0, 8'h05, 8'h03, 2'b00);
    wait_grant("t1_grant", 2'b01);
    chk("t1_busy_accept", {15'd0, busy}, 16'd0);
    @(posedge clock); #1;
    reqValid = 2'b00;
    @(negedge clock);
    chk("t1_busy_exec", {15'd0, busy}, 16'd1);
    chk("t1_rspValid_exec", {14'd0, rspValid}, 16'd0);
    chk("t1_aluA", {8'd0, aluA}, 16'h0005);
    chk("t1_aluB", {8'd0, aluB}, 16'h0003);
    chk("t1_aluCtl", {14'd0, aluControl}, 16'd0);
    wait_rsp("t1");
    chk("t1_busy_resp", {15'd0, busy}, 16'd1);
    @(negedge clock);
    chk("t1_busy_idle", {15'd0, busy}, 16'd0);
    chk("t1_rspValid_drop", {14'd0, rspValid}, 16'd0);
    chk("t1_aluA_hold", {8'd0, aluA}, 16'h0005);

    // Subtract wrap and zero on requester 1
    run_single("sub_wrap", 1, 8'h03, 8'h05, 2'b01);
    run_single("sub_zero", 1, 8'h44, 8'h44, 2'b01);

    // Contention: both valid for four operations, strict alternation
    @(posedge clock); #1;
    reqA0 = 8'hF0; reqB0 = 8'h3C; reqOp0 = 2'b10;
    reqA1 = 8'hF0; reqB1 = 8'h0F; reqOp1 = 2'b11;
    reqValid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) push_exp(0, 8'hF0, 8'h3C, 2'b10);
      else            push_exp(1, 8'hF0, 8'h0F, 2'b11);
    end
    for (int i = 0; i < 4; i++) begin
      wait_grant($sformatf("cont%0d_grant", i), (i % 2 == 0) ? 2'b01 : 2'b10);
      wait_rsp($sformatf("cont%0d", i));
      if (i == 3) reqValid = 2'b00;
    end

    // Response backpressure on requester 0 while requester 1 waits
    @(negedge clock);
    rspReady = 2'b10;
    @(posedge clock); #1;
    reqA0 = 8'h10; reqB0 = 8'h20; reqOp0 = 2'b00; reqValid = 2'b01;
    push_exp(0, 8'h10, 8'h20, 2'b00);
    wait_grant("bp_grant0", 2'b01);
    @(posedge clock); #1;
    reqA1 = 8'h07; reqB1 = 8'h07; reqOp1 = 2'b01; reqValid = 2'b10;
    push_exp(1, 8'h07, 8'h07, 2'b01);
    wait_rsp("bp0");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clock);
      chk($sformatf("bp_hold%0d_valid", i), {14'd0, rspValid}, 16'h0001);
      chk($sformatf("bp_hold%0d_result", i), {8'd0, rspResult}, {8'd0, alu_model(8'h10, 8'h20, 2'b00)});
      chk($sformatf("bp_hold%0d_zero", i), {15'd0, rspZero}, 16'd0);
      chk($sformatf("bp_hold%0d_ready1", i), {14'd0, reqReady}, 16'd0);
    end
    rspReady = 2'b11;
    @(negedge clock);
    chk("bp_grant1_after_hs", {14'd0, reqReady}, 16'h0002);
    @(posedge clock); #1;
    reqValid = 2'b00;
    wait_rsp("bp1");

    // Reset during EXEC discards the operation and restores the pointer
    @(posedge clock); #1;
    reqA0 = 8'h01; reqB0 = 8'h01; reqOp0 = 2'b00; reqValid = 2'b01;
    wait_grant("mid_grant", 2'b01);
    @(posedge clock); #1;
    reqValid = 2'b00;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk_reset_outputs("mid_rst");
    @(negedge clock);
    chk("mid_no_rsp", {14'd0, rspValid}, 16'd0);
    @(posedge clock); #1;
    reqA0 = 8'h0F; reqB0 = 8'h01; reqOp0 = 2'b01;
    reqA1 = 8'hAA; reqB1 = 8'h0F; reqOp1 = 2'b10;
    reqValid = 2'b11;
    push_exp(0, 8'h0F, 8'h01, 2'b01);
    push_exp(1, 8'hAA, 8'h0F, 2'b10);
    wait_grant("post_rst_grant0", 2'b01);
    wait_rsp("post_rst0");
    wait_grant("post_rst_grant1", 2'b10);
    @(posedge clock); #1;
    reqValid = 2'b00;
    wait_rsp("post_rst1");

`ifdef ALU_ARB_STATS_EN
    // Counters since last reset: one grant each so far
    run_single("st_a", 0, 8'h01, 8'h02, 2'b00);
    run_single("st_b", 0, 8'h03, 8'h04, 2'b00);
    run_single("st_c", 1, 8'h05, 8'h06, 2'b00);
    @(negedge clock);
    chk("stats_cnt0", grantCount0, 16'd3);
    chk("stats_cnt1", grantCount1, 16'd2);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("stats_cnt0_rst", grantCount0, 16'd0);
    chk("stats_cnt1_rst", grantCount1, 16'd0);
`endif

    chk("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
